// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI flash responder and its controller-side peers:
// state encoding, command/nibble-count defaults and a nibble select helper.
package qspi_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      MODE   = 3'd3,
      DUMMY  = 3'd4,
      DATA   = 3'd5,
      IGNORE = 3'd6
   } qspi_state_e;

   localparam logic [7:0]  CMD_CODE_DEF      = 8'hEB;
   localparam int unsigned ADDR_BITS_DEF     = 24;
   localparam int unsigned MODE_NIBBLES_DEF  = 2;
   localparam int unsigned DUMMY_NIBBLES_DEF = 4;
   localparam int unsigned CNT_W             = 8;

   function automatic logic [3:0] byte_nibble(input logic [7:0] b, input logic low);
      return low ? b[3:0] : b[7:4];
   endfunction

endpackage

// File: rtl/qspi_input_sync.sv
// Brings the host SCK, select and IO lines into the clk domain and derives
// single-cycle SCK rise/fall strobes from the synchronized clock.
module qspi_input_sync
   import qspi_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       spi_clk_in,
   input  logic       spi_select_in,
   input  logic [3:0] spi_data_in,
   output logic       sck_rise,
   output logic       sck_fall,
   output logic       sel_sync,
   output logic [3:0] data_sync
);

   logic [2:0] sck_q;
   logic [1:0] sel_q;
   logic [3:0] data_q1;
   logic [3:0] data_q2;

   // Idle levels on reset so no spurious edge or select is seen on release.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sck_q   <= '1;
         sel_q   <= '1;
         data_q1 <= '1;
         data_q2 <= '1;
      end else begin
         sck_q   <= {sck_q[1:0], spi_clk_in};
         sel_q   <= {sel_q[0], spi_select_in};
         data_q1 <= spi_data_in;
         data_q2 <= data_q1;
      end
   end

   assign sck_rise  = sck_q[1] & ~sck_q[2];
   assign sck_fall  = ~sck_q[1] & sck_q[2];
   assign sel_sync  = sel_q[1];
   assign data_sync = data_q2;

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI quad-I/O fast-read responder: decodes the command/address from the host
// and streams bytes from a backing store, keeping one byte prefetched ahead.
//  state  | meaning
//  IDLE   | deselected; leaves when select falls (only after select was seen high)
//  CMD    | shifting the command byte in on IO0
//  ADDR   | shifting address nibbles in on IO[3:0]
//  MODE   | counting mode nibbles, values ignored
//  DUMMY  | turnaround; leaves on the first SCK fall after the last dummy rise
//  DATA   | driving one nibble per SCK fall, high nibble first
//  IGNORE | unsupported command; bus stays released until deselect
module qspi_flash_responder
   import qspi_pkg::*;
#(
   parameter int unsigned ADDR_BITS     = ADDR_BITS_DEF,
   parameter logic [7:0]  CMD_CODE      = CMD_CODE_DEF,
   parameter int unsigned MODE_NIBBLES  = MODE_NIBBLES_DEF,
   parameter int unsigned DUMMY_NIBBLES = DUMMY_NIBBLES_DEF
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 spi_clk_in,
   input  logic                 spi_select_in,
   input  logic [3:0]           spi_data_in,
   output logic [3:0]           spi_data_out,
   output logic [3:0]           spi_data_oe,
   output logic [ADDR_BITS-1:0] rd_addr,
   output logic                 rd_req,
   input  logic [7:0]           rd_data,
   input  logic                 rd_valid,
   output logic                 busy,
   output logic                 underrun
);

   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS / 4 - 1);
   localparam logic [CNT_W-1:0] MODE_CNT  = CNT_W'(MODE_NIBBLES);
   localparam logic [CNT_W-1:0] DUMMY_CNT = CNT_W'(DUMMY_NIBBLES);

   logic                 sck_rise;
   logic                 sck_fall;
   logic                 sel_sync;
   logic [3:0]           data_sync;

   qspi_state_e          state;
   qspi_state_e          state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [6:0]           cmd_sr;
   logic [ADDR_BITS-1:0] addr_sr;
   logic [ADDR_BITS-1:0] addr_nxt;
   logic [7:0]           out_byte;
   logic                 low_half;
   logic [7:0]           pf_data;
   logic                 pf_valid;
   logic [1:0]           prime;
   logic                 armed;
   logic                 byte_load;

   qspi_input_sync u_sync (
      .clk           (clk),
      .rstn          (rstn),
      .spi_clk_in    (spi_clk_in),
      .spi_select_in (spi_select_in),
      .spi_data_in   (spi_data_in),
      .sck_rise      (sck_rise),
      .sck_fall      (sck_fall),
      .sel_sync      (sel_sync),
      .data_sync     (data_sync)
   );

   assign addr_nxt  = {addr_sr[ADDR_BITS-5:0], data_sync};
   assign byte_load = !sel_sync && sck_fall &&
                      ((state == DUMMY && cnt == '0) || (state == DATA && low_half));

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (sel_sync) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (armed) state_nxt = CMD;
            CMD:     if (sck_rise && cnt == '0)
                        state_nxt = ({cmd_sr, data_sync[0]} == CMD_CODE) ? ADDR : IGNORE;
            ADDR:    if (sck_rise && cnt == '0) state_nxt = MODE;
            MODE:    if (cnt == '0) state_nxt = DUMMY;
            DUMMY:   if (sck_fall && cnt == '0) state_nxt = DATA;
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      busy         = (state != IDLE);
      spi_data_oe  = 4'h0;
      spi_data_out = 4'h0;
      if (state == DATA) begin
         spi_data_oe  = 4'hF;
         spi_data_out = byte_nibble(out_byte, low_half);
      end
   end

   // A select seen high is required after reset before a transaction may start,
   // and prime keeps the reset value of the synchronizer from counting as one.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt      <= '0;
         cmd_sr   <= '0;
         addr_sr  <= '0;
         out_byte <= '0;
         low_half <= 1'b0;
         pf_data  <= '0;
         pf_valid <= 1'b0;
         prime    <= '0;
         armed    <= 1'b0;
         rd_req   <= 1'b0;
         rd_addr  <= '0;
         underrun <= 1'b0;
      end else begin
         rd_req   <= 1'b0;
         underrun <= 1'b0;
         prime    <= {prime[0], 1'b1};
         if (prime[1] && sel_sync)
            armed <= 1'b1;
         if (rd_valid && state != IDLE) begin
            pf_data  <= rd_data;
            pf_valid <= 1'b1;
         end
         if (sel_sync) begin
            pf_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  cnt      <= CMD_LAST;
                  low_half <= 1'b0;
               end
               CMD: if (sck_rise) begin
                  cmd_sr <= {cmd_sr[5:0], data_sync[0]};
                  cnt    <= (cnt == '0) ? ADDR_LAST : cnt - 1'b1;
               end
               ADDR: if (sck_rise) begin
                  addr_sr <= addr_nxt;
                  if (cnt == '0) begin
                     rd_addr <= addr_nxt;
                     rd_req  <= 1'b1;
                     cnt     <= MODE_CNT;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               MODE: begin
                  if (cnt == '0)    cnt <= DUMMY_CNT;
                  else if (sck_rise) cnt <= cnt - 1'b1;
               end
               DUMMY: if (sck_rise && cnt != '0) cnt <= cnt - 1'b1;
               DATA:  if (sck_fall && !low_half) low_half <= 1'b1;
               default: ;
            endcase
            // A response landing in the load cycle itself is used directly.
            if (byte_load) begin
               out_byte <= pf_valid ? pf_data : (rd_valid ? rd_data : 8'h00);
               underrun <= !(pf_valid || rd_valid);
               pf_valid <= 1'b0;
               low_half <= 1'b0;
               rd_addr  <= rd_addr + 1'b1;
               rd_req   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/qspi_flash_responder.md
QSPI_FLASH_RESPONDER -- requirements
Module: qspi_flash_responder

Interface
REQ-001 Parameter ADDR_BITS, default 24, SHALL set the address width in bits (multiple of 4).
REQ-002 Parameter CMD_CODE, default 8'hEB, SHALL set the only accepted command (quad I/O fast read).
REQ-003 Parameter MODE_NIBBLES, default 2, SHALL set the mode nibbles driven by the host after the address.
REQ-004 Parameter DUMMY_NIBBLES, default 4, SHALL set the turnaround nibbles (host not driving) before data.
REQ-005 clk  in  1  system clock; rising edge only.
REQ-006 rstn  in  1  reset, synchronous, active-low.
REQ-007 spi_clk_in  in  1  SCK from host, asynchronous to clk, idles high.
REQ-008 spi_select_in  in  1  chip select, active-low, asynchronous.
REQ-009 spi_data_in  in  4  IO[3:0] from host, asynchronous.
REQ-010 spi_data_out  out  4  IO[3:0] driven to host.
REQ-011 spi_data_oe  out  4  per-line output enable, 1 = drive.
REQ-012 rd_addr  out  ADDR_BITS  byte address to the backing store.
REQ-013 rd_req  out  1  one-cycle read request; rd_addr is valid in the same cycle.
REQ-014 rd_data  in  8  byte returned by the backing store.
REQ-015 rd_valid  in  1  one-cycle strobe; rd_data is valid in the same cycle.
REQ-016 busy  out  1  high whenever state != IDLE.
REQ-017 underrun  out  1  one-cycle pulse when a byte is needed but its prefetch has not returned.

Function
REQ-018 spi_clk_in, spi_select_in and spi_data_in SHALL each pass through 2 flops; SCK rise/fall SHALL be detected from the synchronized value and a third flop.
REQ-019 clk SHALL be at least 8x the SCK frequency; behaviour below this ratio is undefined.
REQ-020 States SHALL be: IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
REQ-021 In any state, synchronized select high SHALL force IDLE, oe=0 and the prefetch-valid flag clear in the next cycle; rd_valid arriving while in IDLE SHALL be discarded.
REQ-022 IDLE -> CMD SHALL occur when synchronized select goes low; the nibble counter SHALL load 7.
REQ-023 All host input bits/nibbles SHALL be sampled on detected SCK rise, MSB first.
REQ-024 CMD SHALL shift in IO0 for 8 rises; if the byte equals CMD_CODE go to ADDR, else go to IGNORE.
REQ-025 IGNORE SHALL keep oe=0 until select high.
REQ-026 ADDR SHALL shift in ADDR_BITS/4 nibbles on IO[3:0]; on the last rise the address register SHALL load and rd_req SHALL pulse with rd_addr = received address in the next cycle.
REQ-027 MODE SHALL count MODE_NIBBLES rises and ignore their values; DUMMY SHALL then count DUMMY_NIBBLES rises.
REQ-028 On the first SCK fall after the last dummy rise, state SHALL go to DATA, oe SHALL become 4'b1111 and spi_data_out SHALL present the high nibble of the prefetched byte.
REQ-029 In DATA each subsequent SCK fall SHALL advance one nibble: high nibble then low nibble of byte N, then high nibble of byte N+1.
REQ-030 When byte N is loaded into the output shift register, rd_req SHALL pulse for address N+1; the address SHALL wrap at 2^ADDR_BITS.
REQ-031 A byte load with no valid prefetch SHALL pulse underrun, output 4'b0000 for that byte, and still request the next address.
REQ-032 rd_valid SHALL latch rd_data into the prefetch buffer (one byte) and set prefetch-valid; a load clears it.
REQ-033 A transaction SHALL end only by select high; there is no byte limit.
REQ-034 Output nibble change SHALL occur no later than 4 clk after the SCK fall reaches the spi_clk_in pin.

Reset
REQ-035 Under reset: state IDLE, spi_data_oe 0, spi_data_out 0, rd_req 0, rd_addr 0, busy 0, underrun 0, prefetch-valid 0, synchronizer flops 1 (idle levels).
REQ-036 Reset mid-transaction SHALL release the bus (oe=0) in the next cycle; the next transaction SHALL begin only after select is sampled high then low.

Structure
REQ-037 Shared package qspi_pkg SHALL hold the state enum, CMD_CODE default and nibble-count defaults, shared with the controller side.
REQ-038 Sub-module qspi_input_sync SHALL implement the 2-flop synchronizers and the SCK rise/fall detection.

Verification
REQ-039 Host sends 0xEB, addr 0x000100, mode 0x11, 4 dummy; store returns mem[a]=a[7:0]; 4 nibbles -> 0,0,0,1; rd_addr 0x100 then 0x101, 0x102.
REQ-040 Command 0x03 then 40 SCKs -> oe stays 0, no rd_req, busy high until select high.
REQ-041 Address 0xFFFFFF, read 2 bytes -> rd_addr sequence 0xFFFFFF, 0x000000, 0x000001 (wrap).
REQ-042 Store withholds rd_valid for byte 1 -> one underrun pulse, nibbles 0,0 for byte 1, byte 2 correct.
REQ-043 Select raised mid-byte in DATA -> oe=0 within 4 clk; a new 0xEB transaction afterwards returns correct data.
REQ-044 rstn low during ADDR -> all outputs at reset values next cycle; no rd_req until a new full command.
